// File: rtl/lsu_axi_lite.sv
// Multi-cycle load/store unit: accepts one memory op from execute, runs a single
// request/response transaction on the data-memory bus, and reports the result to writeback.
module lsu_axi_lite #(
  parameter int DATA_LEN = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic                is_load,
  input  logic                is_store,
  input  logic [1:0]          size,
  input  logic                load_unsigned,
  input  logic [DATA_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [DATA_LEN-1:0] mem_req_addr,
  output logic [DATA_LEN-1:0] mem_req_wdata,
  output logic [3:0]          mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_resp_rdata,
  output logic                lsu_done,
  output logic [DATA_LEN-1:0] load_data,
  output logic                misalign,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds valid and its payload stable until that edge. mem_resp_valid has no
  // ready and is consumed only while waiting for a response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic       op_is_mem;
  logic       bad_align;
  logic [3:0] st_wmask;
  logic [DATA_LEN-1:0] st_wdata;

  logic [1:0] off_q;
  logic [1:0] size_q;
  logic       uns_q;
  logic       ld_q;

  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_LEN-1:0] ld_ext;

  assign lsu_ready     = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign lsu_done      = (state == DONE);
  assign dbg_state     = state;

  assign op_is_mem = is_load | is_store;

  always_comb begin
    bad_align = 1'b0;
    st_wmask  = 4'b1111;
    st_wdata  = wdata;
    case (size)
      2'b00: begin
        st_wmask = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        bad_align = addr[0];
        st_wmask  = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata  = {2{wdata[15:0]}};
      end
      2'b10: bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
  end

  // Response extraction uses the offset/size latched at accept, not the live inputs.
  always_comb begin
    byte_sel = mem_resp_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = {{(DATA_LEN-8){~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = {{(DATA_LEN-16){~uns_q & half_sel[15]}}, half_sel};
      default: ld_ext = mem_resp_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (lsu_valid) begin
          if (!op_is_mem || bad_align) state_nxt = DONE;
          else                         state_nxt = REQ;
        end
      end
      REQ:  if (mem_req_ready)  state_nxt = RESP;
      RESP: if (mem_resp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= 4'b0000;
      load_data     <= '0;
      misalign      <= 1'b0;
      off_q         <= 2'b00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      ld_q          <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            if (!op_is_mem) begin
              load_data <= '0;
              misalign  <= 1'b0;
            end else if (bad_align) begin
              load_data <= '0;
              misalign  <= 1'b1;
            end else begin
              // is_load wins when both op bits are set.
              off_q         <= addr[1:0];
              size_q        <= size;
              uns_q         <= load_unsigned;
              ld_q          <= is_load;
              mem_req_addr  <= {addr[DATA_LEN-1:2], 2'b00};
              mem_req_wen   <= ~is_load;
              mem_req_wmask <= is_load ? 4'b0000 : st_wmask;
              mem_req_wdata <= is_load ? '0 : st_wdata;
            end
          end
        end
        RESP: begin
          if (mem_resp_valid) begin
            load_data <= ld_q ? ld_ext : '0;
            misalign  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_lite.sv
// Directed and randomized bench for lsu_axi_lite, checked against a byte-arithmetic
// model of the access rules with immediate assertions.
module tb_lsu_axi_lite;

  logic        sys_clk;
  logic        sys_rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        lsu_done;
  logic [31:0] load_data;
  logic        misalign;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic        bus;
    logic        mis;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] ldata;
  } exp_t;

  lsu_axi_lite #(.DATA_LEN(32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .is_load(is_load), .is_store(is_store), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .lsu_done(lsu_done), .load_data(load_data), .misalign(misalign),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: bytes counted, lanes found by arithmetic on the byte offset.
  function automatic exp_t model(input logic ld, input logic st, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a,
                                 input logic [31:0] w, input logic [31:0] r);
    exp_t e;
    int o;
    int nb;
    logic [63:0] v;
    logic [31:0] lane;
    e  = '0;
    o  = int'(a % 4);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    if (!ld && !st) return e;
    if (nb == 0 || (o % nb) != 0) begin
      e.mis = 1'b1;
      return e;
    end
    e.bus  = 1'b1;
    e.addr = a - 32'(o);
    e.wen  = ~ld;
    if (ld) begin
      v = 64'(r >> (8 * o)) & ((64'd1 << (8 * nb)) - 64'd1);
      if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
        v = v - (64'd1 << (8 * nb));
      e.ldata = v[31:0];
    end else begin
      e.wmask = 4'(((1 << nb) - 1) << o);
      lane    = w & 32'((64'd1 << (8 * nb)) - 64'd1);
      e.wdata = lane * ((nb == 1) ? 32'h01010101 : (nb == 2) ? 32'h00010001 : 32'h1);
    end
    return e;
  endfunction

  // Driver: one op from accept to the cycle after lsu_done, checking every cycle.
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] w, input logic [31:0] r,
                       input int rdly, input int respdly, input logic spur,
                       output logic [31:0] obs_ld);
    exp_t e;
    logic [31:0] exp_ld;
    e = model(ld, st, sz, uns, a, w, r);
    chk1("ready_idle", lsu_ready, 1'b1);
    lsu_valid = 1'b1; is_load = ld; is_store = st; size = sz;
    load_unsigned = uns; addr = a; wdata = w;
    exp_q.push_back(e.ldata);
    @(negedge sys_clk);
    lsu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    addr = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 3));
    if (e.bus) begin
      for (int i = 0; i <= rdly; i++) begin
        chk1("req_valid", mem_req_valid, 1'b1);
        chk1("req_ready_low", lsu_ready, 1'b0);
        chk1("req_no_done", lsu_done, 1'b0);
        chk1("req_wen", mem_req_wen, e.wen);
        chk("req_addr", mem_req_addr, e.addr);
        chk("req_wdata", mem_req_wdata, e.wdata);
        chk("req_wmask", 32'(mem_req_wmask), 32'(e.wmask));
        if (i == rdly) begin
          mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        end else begin
          mem_req_ready = 1'b0; mem_resp_valid = spur; mem_resp_rdata = $urandom;
        end
        @(negedge sys_clk);
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= respdly; i++) begin
        chk1("resp_req_low", mem_req_valid, 1'b0);
        chk1("resp_no_done", lsu_done, 1'b0);
        mem_resp_valid = (i == respdly);
        mem_resp_rdata = (i == respdly) ? r : $urandom;
        @(negedge sys_clk);
      end
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
    end else begin
      chk1("nobus_req_low", mem_req_valid, 1'b0);
    end
    exp_ld = exp_q.pop_front();
    chk1("done", lsu_done, 1'b1);
    chk1("done_misalign", misalign, e.mis);
    chk("done_load_data", load_data, exp_ld);
    chk1("done_req_low", mem_req_valid, 1'b0);
    obs_ld = load_data;
    @(negedge sys_clk);
    chk1("done_pulse", lsu_done, 1'b0);
    chk1("back_idle", lsu_ready, 1'b1);
    chk("held_load_data", load_data, exp_ld);
    chk1("held_misalign", misalign, e.mis);
  endtask

  logic [31:0] obs;

  initial begin
    sys_rst = 1'b1; lsu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    size = 2'b00; load_unsigned = 1'b0; addr = '0; wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk1("rst_ready", lsu_ready, 1'b1);
    chk1("rst_req_valid", mem_req_valid, 1'b0);
    chk1("rst_done", lsu_done, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    chk1("rst_misalign", misalign, 1'b0);

    // Load word, minimum latency
    do_op(1, 0, 2'b10, 0, 32'h80000004, 32'h0, 32'hDEADBEEF, 0, 0, 0, obs);
    chk("lw_value", obs, 32'hDEADBEEF);
    // Signed and unsigned byte from lane 3
    do_op(1, 0, 2'b00, 0, 32'h80000003, 32'h0, 32'h80FF7F01, 0, 0, 0, obs);
    chk("lb_value", obs, 32'hFFFFFF80);
    do_op(1, 0, 2'b00, 1, 32'h80000003, 32'h0, 32'h80FF7F01, 0, 0, 0, obs);
    chk("lbu_value", obs, 32'h00000080);
    // Store upper half
    do_op(0, 1, 2'b01, 0, 32'h80000102, 32'h1234ABCD, 32'h0, 0, 1, 0, obs);
    chk("sh_load_data_zero", obs, 32'h0);
    // Backpressure with spurious responses during REQ
    do_op(1, 0, 2'b01, 0, 32'h80000202, 32'h0, 32'h9ABC1234, 5, 2, 1, obs);
    chk("lh_bp_value", obs, 32'hFFFF9ABC);
    // Misaligned word and illegal size
    do_op(1, 0, 2'b10, 0, 32'h80000002, 32'h0, 32'h0, 0, 0, 0, obs);
    do_op(0, 1, 2'b11, 0, 32'h80000000, 32'h55, 32'h0, 0, 0, 0, obs);
    // Neither load nor store
    do_op(0, 0, 2'b10, 0, 32'h80000000, 32'h0, 32'h0, 0, 0, 0, obs);
    // Both set: load wins
    do_op(1, 1, 2'b10, 0, 32'h80000010, 32'hFFFFFFFF, 32'h0BADF00D, 1, 0, 0, obs);
    do_op(1, 0, 2'b10, 0, 32'h80000020, 32'h0, 32'hCAFEF00D, 0, 0, 0, obs);

    // Reset while waiting in RESP
    lsu_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; size = 2'b00;
    addr = 32'h80000301; wdata = 32'h000000A5;
    @(negedge sys_clk);
    lsu_valid = 1'b0; is_store = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge sys_clk);
    mem_req_ready = 1'b0;
    chk1("pre_rst_in_resp", mem_req_valid, 1'b0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk1("midrst_ready", lsu_ready, 1'b1);
    chk1("midrst_req_valid", mem_req_valid, 1'b0);
    chk1("midrst_wen", mem_req_wen, 1'b0);
    chk("midrst_addr", mem_req_addr, 32'h0);
    chk("midrst_wdata", mem_req_wdata, 32'h0);
    chk("midrst_wmask", 32'(mem_req_wmask), 32'h0);
    chk1("midrst_done", lsu_done, 1'b0);
    chk("midrst_load_data", load_data, 32'h0);
    chk1("midrst_misalign", misalign, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678;
    @(negedge sys_clk);
    mem_resp_valid = 1'b0;
    chk1("late_resp_no_done", lsu_done, 1'b0);
    chk1("late_resp_ready", lsu_ready, 1'b1);
    @(negedge sys_clk);
    chk1("late_resp_no_done2", lsu_done, 1'b0);
    chk("late_resp_load_data", load_data, 32'h0);

    // Randomized ops
    for (int n = 0; n < 60; n++) begin
      logic ld, st;
      int kind;
      kind = $urandom_range(0, 9);
      ld = (kind < 5) || (kind == 9);
      st = (kind >= 5);
      if (kind == 8) begin ld = 1'b0; st = 1'b0; end
      do_op(ld, st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h80000000 + 32'($urandom_range(0, 255)), $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), obs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
